// File: rtl/axis_packet_mux.sv
// N-to-1 AXI-Stream packet mux: round-robin, packet-atomic grant, output registered through a 2-entry skid buffer.
// Optional build macro AXIS_PACKET_MUX_TID_STAMP_EN replaces m_tid with the granted input index.
module axis_packet_mux #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 512,
  parameter int DEST_W = 5,
  parameter int ID_W   = 5,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   s_tdata,
  input  logic [N_IN*DEST_W-1:0]   s_tdest,
  input  logic [N_IN*ID_W-1:0]     s_tid,
  input  logic [N_IN-1:0]          s_tlast,
  input  logic [N_IN-1:0]          s_tvalid,
  output logic [N_IN-1:0]          s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [DEST_W-1:0]        m_tdest,
  output logic [ID_W-1:0]          m_tid,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy
);

  // Handshake: a beat moves on any edge where valid && ready; ready never depends on valid.
  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
  logic             found;
  logic [1:0]       cnt;
  beat_t            buf0, buf1, in_beat;
  logic             sel_valid, push, pop;

`ifdef AXIS_PACKET_MUX_TID_STAMP_EN
  if (ID_W < IDX_W) begin : g_tid_w_check
    $error("axis_packet_mux: ID_W must be >= IDX_W when tid stamping is enabled");
  end
`endif

  // Granted lane payload and ready; ready comes only from registered state.
  always_comb begin
    in_beat   = '0;
    sel_valid = 1'b0;
    s_tready  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        in_beat.data = s_tdata[i*DATA_W +: DATA_W];
        in_beat.dest = s_tdest[i*DEST_W +: DEST_W];
`ifdef AXIS_PACKET_MUX_TID_STAMP_EN
        in_beat.id   = ID_W'(grant_idx);
`else
        in_beat.id   = s_tid[i*ID_W +: ID_W];
`endif
        in_beat.last = s_tlast[i];
        sel_valid    = s_tvalid[i];
        s_tready[i]  = (state == LOCKED) && (cnt != 2'd2);
      end
    end
  end

  assign push = (state == LOCKED) && (cnt != 2'd2) && sel_valid;
  assign pop  = (cnt != 2'd0) && m_tready;

  // Round-robin search starting at rr_ptr, wrapping to 0.
  always_comb begin
    found     = 1'b0;
    grant_nxt = grant_idx;
    for (int k = 0; k < N_IN; k++) begin
      if (!found && s_tvalid[(int'(rr_ptr) + k) % N_IN]) begin
        found     = 1'b1;
        grant_nxt = IDX_W'((int'(rr_ptr) + k) % N_IN);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE:   if (found) state_nxt = LOCKED;
      LOCKED: begin
        if (push && in_beat.last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = IDX_W'((int'(grant_idx) + 1) % N_IN);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (state == IDLE && found) grant_idx <= grant_nxt;
    end
  end

  // Skid buffer: buf0 is the head; it only changes when empty or popped, so m_* holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= in_beat;
          else             buf1 <= in_beat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0 <= in_beat;
          end else begin
            buf0 <= buf1;
            buf1 <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tdata  = buf0.data;
  assign m_tdest  = buf0.dest;
  assign m_tid    = buf0.id;
  assign m_tlast  = buf0.last;
  assign m_tvalid = (cnt != 2'd0);
  assign busy     = (state == LOCKED);

endmodule

// File: tb/tb_axis_packet_mux.sv
// Bench for axis_packet_mux: queue-based reference model checked every cycle, plus directed packet scenarios.
module tb_axis_packet_mux;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int DEST = 5;
  localparam int IDW  = 5;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*DEST-1:0] s_tdest = '0;
  logic [N*IDW-1:0]  s_tid = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [DEST-1:0]   m_tdest;
  logic [IDW-1:0]    m_tid;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  axis_packet_mux #(.N_IN(N), .DATA_W(DW), .DEST_W(DEST), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tid(s_tid), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tid(m_tid), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DEST-1:0] dest;
    logic [IDW-1:0]  id;
    logic            last;
  } beat_t;
  typedef struct packed {
    logic [3:0] src;
    beat_t      b;
  } ent_t;

  beat_t         src_q[N][$];
  logic [DW-1:0] sent_q[N][$];
  ent_t          exp_q[$];
  int            out_src[$];
  int            out_cyc[$];
  logic [DW-1:0] out_data[$];
  logic          out_last[$];
  logic [IDW-1:0] out_tid[$];

  int n_checks = 0;
  int n_errors = 0;
  int gap_pct = 0;
  int ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [IDW-1:0] exp_tid(input int src, input logic [IDW-1:0] id);
`ifdef AXIS_PACKET_MUX_TID_STAMP_EN
    return IDW'(src);
`else
    return id;
`endif
  endfunction

  function automatic beat_t lane(input int i);
    beat_t r;
    r.data = s_tdata[i*DW +: DW];
    r.dest = s_tdest[i*DEST +: DEST];
    r.id   = s_tid[i*IDW +: IDW];
    r.last = s_tlast[i];
    return r;
  endfunction

  // ---------------- driver ----------------
  logic [N-1:0] hs;
  always begin
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
        s_tdata[i*DW +: DW]     = src_q[i][0].data;
        s_tdest[i*DEST +: DEST] = src_q[i][0].dest;
        s_tid[i*IDW +: IDW]     = src_q[i][0].id;
        s_tlast[i]              = src_q[i][0].last;
        s_tvalid[i]             = 1'b1;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    m_tready = (int'($urandom_range(99)) < ready_pct);
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Model: a packet-atomic round-robin arbiter over a FIFO of in-flight beats (depth 2).
  logic          m_locked = 1'b0;
  int            m_g = 0;
  int            m_rr = 0;
  int            acc_cnt[N];
  logic [N-1:0]  exp_rdy;
  logic          do_push, found, prev_stall = 1'b0;
  beat_t         nb, prev_b;
  ent_t          ne;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_locked = 1'b0; m_g = 0; m_rr = 0; prev_stall = 1'b0;
      for (int i = 0; i < N; i++) acc_cnt[i] = 0;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_s_tready", s_tready, 0);
    end else begin
      exp_rdy = '0;
      if (m_locked && exp_q.size() < 2) exp_rdy[m_g] = 1'b1;
      check("s_tready", s_tready, exp_rdy);
      check("busy", busy, m_locked);
      check("grant_idx", grant_idx, m_g);
      check("m_tvalid", m_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("m_tdata", m_tdata, exp_q[0].b.data);
        check("m_tdest", m_tdest, exp_q[0].b.dest);
        check("m_tid", m_tid, exp_q[0].b.id);
        check("m_tlast", m_tlast, exp_q[0].b.last);
      end
      if (prev_stall) begin
        check("stall_data_stable", m_tdata, prev_b.data);
        check("stall_last_stable", m_tlast, prev_b.last);
      end
      prev_stall  = m_tvalid && !m_tready;
      prev_b.data = m_tdata; prev_b.dest = m_tdest; prev_b.id = m_tid; prev_b.last = m_tlast;

      do_push = m_locked && exp_q.size() < 2 && s_tvalid[m_g];
      if (exp_q.size() != 0 && m_tready) begin
        out_src.push_back(int'(exp_q[0].src));
        out_cyc.push_back(cyc);
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        out_tid.push_back(m_tid);
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        nb = lane(m_g);
        nb.id = exp_tid(m_g, nb.id);
        ne.src = 4'(m_g);
        ne.b = nb;
        exp_q.push_back(ne);
        acc_cnt[m_g]++;
        if (nb.last) begin
          m_locked = 1'b0;
          m_rr = (m_g + 1) % N;
        end
      end else if (!m_locked && s_tvalid != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && s_tvalid[(m_rr + k) % N]) begin
            found = 1'b1;
            m_g = (m_rr + k) % N;
          end
        end
        m_locked = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int src, input int len, input logic [IDW-1:0] tid, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = (base != '0) ? base + DW'(k) : DW'($urandom);
      b.dest = DEST'($urandom);
      b.id   = tid;
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      sent_q[src].push_back(b.data);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      sent_q[i].delete();
    end
    out_src.delete(); out_cyc.delete(); out_data.delete(); out_last.delete(); out_tid.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      @(posedge clk);
      n++;
      pending = m_locked || exp_q.size() != 0;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) pending = 1'b1;
    end
    if (pending) check({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Every output beat must be the next unsent beat of its source; nothing may be left over.
  task automatic check_log(input string name);
    for (int k = 0; k < out_src.size(); k++) begin
      if (sent_q[out_src[k]].size() == 0) check({name, "_extra_beat"}, 1, 0);
      else check({name, "_order"}, out_data[k], sent_q[out_src[k]].pop_front());
    end
    for (int i = 0; i < N; i++) check({name, "_leftover"}, sent_q[i].size(), 0);
  endtask

  // ---------------- tests ----------------
  int t0;
  int total;
  int s;
  initial begin
    #2;
    check("reset_s_tready", s_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tlast", m_tlast, 0);
    check("reset_m_tdata", m_tdata, 0);
    check("reset_m_tdest", m_tdest, 0);
    check("reset_m_tid", m_tid, 0);
    check("reset_grant_idx", grant_idx, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // single 3-beat packet on input 2: latency, contiguity, tlast
    @(posedge clk); #3;
    send(2, 3, 5'h02, 32'hA);
    @(posedge clk); #2 t0 = cyc;
    wait_idle("t1", 50);
    check("t1_count", out_src.size(), 3);
    check("t1_first_cycle", out_cyc[0], t0 + 2);
    check("t1_second_cycle", out_cyc[1], t0 + 3);
    check("t1_third_cycle", out_cyc[2], t0 + 4);
    check("t1_data0", out_data[0], 32'hA);
    check("t1_data1", out_data[1], 32'hB);
    check("t1_data2", out_data[2], 32'hC);
    check("t1_last_pattern", {out_last[0], out_last[1], out_last[2]}, 3'b001);
    check("t1_grant", grant_idx, 2);
    check_log("t1");

    // all inputs continuously valid with 2-beat packets
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) send(i, 2, IDW'(i), '0);
    @(posedge clk); #2 t0 = cyc;
    wait_idle("t2", 200);
    check("t2_count", out_src.size(), 16);
    for (int p = 0; p < 8; p++) begin
      check("t2_pkt_src_a", out_src[2*p], p % 4);
      check("t2_pkt_src_b", out_src[2*p+1], p % 4);
      check("t2_pkt_last", {out_last[2*p], out_last[2*p+1]}, 2'b01);
    end
    check("t2_last_cycle", out_cyc[15], t0 + 24);
    check_log("t2");

    // backpressure mid-packet with a competing input
    do_reset();
    ready_pct = 0;
    send(1, 5, 5'h01, '0);
    send(3, 2, 5'h03, '0);
    @(posedge clk); #2 t0 = cyc;
    repeat (10) @(posedge clk);
    #2;
    check("t3_accepted_in1", acc_cnt[1], 2);
    check("t3_accepted_in3", acc_cnt[3], 0);
    check("t3_s_tready_low", s_tready, 0);
    check("t3_grant", grant_idx, 1);
    ready_pct = 100;
    wait_idle("t3", 100);
    check("t3_count", out_src.size(), 7);
    for (int k = 0; k < 7; k++) check("t3_src_order", out_src[k], (k < 5) ? 1 : 3);
    check_log("t3");

    // single-beat packets on inputs 0 and 1 with random downstream ready
    do_reset();
    ready_pct = 50;
    for (int k = 0; k < 10; k++) begin
      send(0, 1, 5'h00, '0);
      send(1, 1, 5'h01, '0);
    end
    wait_idle("t4", 400);
    check("t4_count", out_src.size(), 20);
    check_log("t4");

    // asynchronous reset in the middle of a 5-beat packet
    do_reset();
    ready_pct = 100;
    send(2, 5, 5'h02, '0);
    t0 = 0;
    while (acc_cnt[2] < 2 && t0 < 50) begin
      @(posedge clk);
      t0++;
    end
    check("t5_reached_beat2", acc_cnt[2], 2);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_m_tvalid", m_tvalid, 0);
    check("t5_async_m_tdata", m_tdata, 0);
    check("t5_async_m_tlast", m_tlast, 0);
    check("t5_async_s_tready", s_tready, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_grant", grant_idx, 0);
    clear_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t5_quiet_after_reset", m_tvalid, 0);
    send(3, 1, 5'h03, '0);
    send(1, 2, 5'h01, '0);
    wait_idle("t5", 50);
    check("t5_count", out_src.size(), 3);
    check("t5_first_src", out_src[0], 1);
    check_log("t5");

    // tid pass-through or stamping
    do_reset();
    send(3, 1, 5'h1F, '0);
    wait_idle("t6", 50);
    check("t6_count", out_src.size(), 1);
`ifdef AXIS_PACKET_MUX_TID_STAMP_EN
    check("t6_tid", out_tid[0], 5'd3);
`else
    check("t6_tid", out_tid[0], 5'h1F);
`endif
    check_log("t6");

    // randomized traffic with input gaps and backpressure
    do_reset();
    gap_pct = 20;
    ready_pct = 70;
    total = 0;
    for (int p = 0; p < 40; p++) begin
      s = int'($urandom_range(N - 1));
      t0 = int'($urandom_range(4, 1));
      send(s, t0, IDW'($urandom), '0);
      total += t0;
    end
    wait_idle("t7", 3000);
    check("t7_count", out_src.size(), total);
    check_log("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
